cpu_state_dump: RTL and testbench

- Debug read-out engine for the 5-stage MIPS core.
- On request it walks the register file (R0..R31), then the first dm_count data-memory words.
- It emits each word, tagged, on a valid/ready stream to an off-chip host or bench monitor.
- It is the read/dump counterpart of the bench-side register and DM preload path.
- While active it asserts cpu_hold so the pipeline freezes and the snapshot is coherent.

---
 rtl/cpu_state_dump.sv | 118 +++++++++++
 tb/tb_cpu_state_dump.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_dump.sv
// Debug read-out engine: on request, freezes the core and streams the register
// file followed by the first dm_count data-memory words over a valid/ready port.
// Each word is tagged {is_dm, index}. The engine only reads; it never writes state.
module cpu_state_dump #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned DM_WORDS  = 128,
  parameter int unsigned DM_ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DM_ADDR_W:0]   dm_count,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           reg_raddr,
  input  logic [31:0]          reg_rdata,
  output logic [DM_ADDR_W-1:0] dm_raddr,
  input  logic [31:0]          dm_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [7:0]           out_tag,
  output logic                 out_last
);

  localparam int unsigned CntW = DM_ADDR_W + 1;
  localparam int unsigned IdxW = DM_ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic              sel_q;  // 0 = register file, 1 = data memory

  logic [CntW-1:0]   cnt_clamped;
  logic              reg_end;
  logic              last_word;

  // Clamp the requested DM length, and decode end-of-section / end-of-dump.
  always_comb begin
    cnt_clamped = (dm_count > CntW'(DM_WORDS)) ? CntW'(DM_WORDS) : dm_count;
    reg_end     = !sel_q && (idx_q == IdxW'(NUM_REGS - 1));
    // With cnt == 0 the dump ends on the last register and DM is never addressed.
    last_word   = sel_q ? ({1'b0, idx_q} == (cnt_q - CntW'(1)))
                        : (reg_end && (cnt_q == '0));
  end

  // Read addresses follow the walk; the unselected port is parked at 0.
  always_comb begin
    reg_raddr = sel_q ? 5'd0 : 5'(idx_q);
    dm_raddr  = sel_q ? idx_q : '0;
    cpu_hold  = busy;
  end

  // Dump sequencer: LOAD captures one word, SEND holds it until the host takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      sel_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            cnt_q   <= cnt_clamped;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          out_data  <= sel_q ? dm_rdata : reg_rdata;
          out_tag   <= {sel_q, 7'(idx_q)};
          out_last  <= last_word;
          out_valid <= 1'b1;
          state_q   <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else if (reg_end) begin
              sel_q   <= 1'b1;
              idx_q   <= '0;
              state_q <= StLoad;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= StLoad;
            end
          end
        end
        StDone: begin
          // Park the walk so both read addresses return to 0 while idle.
          done    <= 1'b0;
          idx_q   <= '0;
          sel_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_state_dump.sv
// Directed bench for cpu_state_dump: bench-side register file and DM models feed
// the read ports; each streamed word is checked against hand-derived tag/data/last.
module tb_cpu_state_dump;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned DmWords = 128;
  localparam int unsigned DmAddrW = 7;

  logic               clk;
  logic               rst;
  logic               start;
  logic [DmAddrW:0]   dm_count;
  logic               cpu_hold;
  logic               busy;
  logic               done;
  logic [4:0]         reg_raddr;
  logic [31:0]        reg_rdata;
  logic [DmAddrW-1:0] dm_raddr;
  logic [31:0]        dm_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [7:0]         out_tag;
  logic               out_last;

  logic [31:0] rf [NumRegs];
  logic [31:0] dm [DmWords];

  int n_checks = 0;
  int n_fail   = 0;

  cpu_state_dump #(
    .NUM_REGS  (NumRegs),
    .DM_WORDS  (DmWords),
    .DM_ADDR_W (DmAddrW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dm_count  (dm_count),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .reg_raddr (reg_raddr),
    .reg_rdata (reg_rdata),
    .dm_raddr  (dm_raddr),
    .dm_rdata  (dm_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_last  (out_last)
  );

  assign reg_rdata = rf[reg_raddr];
  assign dm_rdata  = dm[dm_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One dump: start, consume words (optional stall / re-start / reset), then check done.
  task automatic run_dump(input int cnt_in, input int exp_words, input int stall_word,
                          input int stall_cycles, input int restart_word,
                          input int reset_word);
    int          wc;
    int          stalled;
    int          cycles;
    int          dones;
    bit          got_last;
    bit          prev_stall;
    bit          dm_touched;
    bit          aborted;
    logic [7:0]  etag;
    logic [31:0] edata;
    wc = 0; stalled = 0; cycles = 0; dones = 0;
    got_last = 1'b0; prev_stall = 1'b0; dm_touched = 1'b0; aborted = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    dm_count  = 8'(cnt_in);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("first_busy", {31'd0, busy}, 32'd1);
    check_eq("first_hold", {31'd0, cpu_hold}, 32'd1);
    check_eq("first_valid_low", {31'd0, out_valid}, 32'd0);
    while (!got_last && !aborted && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (done) dones++;
      if (dm_raddr != '0) dm_touched = 1'b1;
      if (prev_stall) check_eq("valid_held", {31'd0, out_valid}, 32'd1);
      prev_stall = 1'b0;
      if (out_valid) begin
        if (wc < NumRegs) begin
          etag  = 8'(wc);
          edata = rf[wc];
        end else begin
          etag  = 8'(128 + wc - NumRegs);
          edata = (wc < NumRegs + DmWords) ? dm[wc - NumRegs] : 32'hDEAD_BEEF;
        end
        check_eq("tag", {24'd0, out_tag}, {24'd0, etag});
        check_eq("data", out_data, edata);
        check_eq("last", {31'd0, out_last}, {31'd0, wc == exp_words - 1});
        check_eq("hold", {31'd0, cpu_hold}, 32'd1);
        if (wc == reset_word) begin
          rst       = 1'b1;
          out_ready = 1'b0;
          aborted   = 1'b1;
        end else begin
          if (wc == restart_word) start = 1'b1;
          if (wc == stall_word && stalled < stall_cycles) begin
            out_ready  = 1'b0;
            stalled++;
            prev_stall = 1'b1;
          end else begin
            out_ready = 1'b1;
            got_last  = out_last;
            wc++;
          end
        end
      end
    end
    if (!aborted) begin
      check_eq("word_count", wc, exp_words);
      check_eq("no_early_done", dones, 0);
      if (cnt_in == 0) check_eq("dm_untouched", {31'd0, dm_touched}, 32'd0);
      @(negedge clk);
      check_eq("done_pulse", {31'd0, done}, 32'd1);
      check_eq("done_busy", {31'd0, busy}, 32'd0);
      check_eq("done_hold", {31'd0, cpu_hold}, 32'd0);
      check_eq("done_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check_eq("done_cleared", {31'd0, done}, 32'd0);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({pfx, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check_eq({pfx, "_done"}, {31'd0, done}, 32'd0);
    check_eq({pfx, "_last"}, {31'd0, out_last}, 32'd0);
    check_eq({pfx, "_data"}, out_data, 32'd0);
    check_eq({pfx, "_tag"}, {24'd0, out_tag}, 32'd0);
    check_eq({pfx, "_raddr"}, {27'd0, reg_raddr}, 32'd0);
    check_eq({pfx, "_dmaddr"}, {25'd0, dm_raddr}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NumRegs; i++) rf[i] = 32'hA000_0000 + i;
    for (int i = 0; i < DmWords; i++) dm[i] = 32'hD000_0000 + i;
    rf[0] = 32'd0; rf[1] = 32'd1; rf[2] = 32'd2;
    dm[0] = 32'd9; dm[1] = 32'd3;

    rst = 1'b1; start = 1'b0; dm_count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic dump: 32 registers + 2 DM words.
    run_dump(2, 34, -1, 0, -1, -1);
    // Backpressure on word 1 for 5 cycles.
    run_dump(2, 34, 1, 5, -1, -1);
    // Registers only.
    run_dump(0, 32, -1, 0, -1, -1);
    // Oversized request clamps to the full DM.
    run_dump(200, 160, -1, 0, -1, -1);
    // Reset while word 10 is pending, then a fresh dump.
    run_dump(2, 34, -1, 0, -1, 10);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    run_dump(2, 34, -1, 0, -1, -1);
    // Start during a running dump is ignored.
    run_dump(2, 34, -1, 0, 5, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
